// File: rtl/wb_ext_pkg.sv
// Shared constants, state type and burst address helper for the external-port responder.
package wb_ext_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CLASSIC_TERM,
    ST_BURST
  } wb_resp_state_t;

  // Address of the next beat; wrapping bursts only advance the low word-address bits.
  function automatic logic [31:0] wb_next_adr(input logic [31:0] adr, input logic [1:0] bte);
    logic [31:0] lin;
    lin = adr + 32'd4;
    case (bte)
      BTE_WRAP4:  wb_next_adr = {adr[31:4], lin[3:2], adr[1:0]};
      BTE_WRAP8:  wb_next_adr = {adr[31:5], lin[4:2], adr[1:0]};
      BTE_WRAP16: wb_next_adr = {adr[31:6], lin[5:2], adr[1:0]};
      default:    wb_next_adr = lin;
    endcase
  endfunction

endpackage

// File: rtl/wb_ext_resp_mem.sv
// Single-port backing RAM: byte-lane writes, registered read data one cycle after the address.
module wb_ext_resp_mem #(
  parameter int unsigned WORDS = 16384,
  parameter int unsigned AW    = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Byte-lane write and synchronous read; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ext_responder.sv
// Wishbone B3 slave backing one tile's external master port with local memory.
//
// state           | meaning
// ST_IDLE         | no transfer; sample cyc&stb
// ST_WAIT         | counting programmed wait states before the first response
// ST_CLASSIC_TERM | single ack/err cycle; forces a gap before the next request
// ST_BURST        | incrementing burst; exp_q is the address of the beat on the bus
//
// In a burst the ack for the next beat is committed at the edge the current beat
// completes, so it is visible for one cycle even if the master stalls; after that
// ack stays low until stb returns. A beat whose address disagrees with exp_q is
// never written and ends the burst with err.
module wb_ext_responder
  import wb_ext_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           MEM_SIZE    = 65536,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_cab_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o
);

  localparam int unsigned MEM_WORDS = MEM_SIZE / 4;
  localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_resp_state_t        state_q;
  logic                  ack_q;
  logic                  err_q;
  logic [3:0]            wait_q;
  logic [ADDR_WIDTH-1:0] exp_q;

  logic                  req;
  logic                  beat_done;
  logic                  term_now;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] nxt_adr;
  logic [ADDR_WIDTH-1:0] ram_adr;
  logic [ADDR_WIDTH-1:0] ram_off;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_bits;

  function automatic logic adr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < ADDR_WIDTH'(MEM_SIZE)) && (a[1:0] == 2'b00);
  endfunction

  assign req       = wb_cyc_i & wb_stb_i;
  assign beat_done = ack_q & req;
  assign nxt_adr   = wb_next_adr(exp_q, wb_bte_i);
  assign term_now  = req && (((state_q == ST_IDLE) && (WAIT_STATES == 0)) ||
                             ((state_q == ST_WAIT) && (wait_q == 4'd0)));

  // Writes land on the completing edge of an acked beat, so a dropped cyc leaves memory untouched.
  always_comb begin
    wr_en   = beat_done & wb_we_i & ((state_q != ST_BURST) || (wb_adr_i == exp_q));
    ram_adr = (state_q == ST_BURST) ? exp_q : wb_adr_i;
    if ((state_q == ST_BURST) && beat_done && !wb_we_i) ram_adr = nxt_adr;
  end

  assign ram_off     = ram_adr - BASE_ADDR;
  assign unused_bits = ^{wb_cab_i, ram_off[1:0], ram_off[ADDR_WIDTH-1:MEM_AW+2]};

  wb_ext_resp_mem #(
    .WORDS(MEM_WORDS),
    .AW   (MEM_AW)
  ) u_mem (
    .clk    (clk),
    .addr_i (ram_off[MEM_AW+1:2]),
    .we_i   (wr_en ? wb_sel_i : 4'b0000),
    .wdata_i(wb_dat_i),
    .rdata_o(ram_rdata)
  );

  // Transfer FSM with registered ack/err, wait counter and burst address tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= 4'd0;
      exp_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (!wb_cyc_i) begin
        state_q <= ST_IDLE;
      end else if (term_now) begin
        if (!adr_ok(wb_adr_i)) begin
          err_q   <= 1'b1;
          state_q <= ST_CLASSIC_TERM;
        end else begin
          ack_q   <= 1'b1;
          exp_q   <= wb_adr_i;
          state_q <= (wb_cti_i == CTI_INCR) ? ST_BURST : ST_CLASSIC_TERM;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (wb_stb_i) begin
              wait_q  <= WAIT_LOAD;
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (!wb_stb_i)              state_q <= ST_IDLE;
            else if (wait_q != 4'd0)    wait_q  <= wait_q - 4'd1;
          end
          ST_CLASSIC_TERM: state_q <= ST_IDLE;
          ST_BURST: begin
            if (wb_stb_i) begin
              if (wb_adr_i != exp_q) begin
                err_q   <= 1'b1;
                state_q <= ST_CLASSIC_TERM;
              end else if (ack_q) begin
                if (wb_cti_i != CTI_INCR) begin
                  state_q <= ST_IDLE;
                end else if (!adr_ok(nxt_adr)) begin
                  exp_q   <= nxt_adr;
                  err_q   <= 1'b1;
                  state_q <= ST_CLASSIC_TERM;
                end else begin
                  exp_q <= nxt_adr;
                  ack_q <= 1'b1;
                end
              end else begin
                ack_q <= 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = ack_q ? ram_rdata : '0;

endmodule
